vi_main_mem: RTL and testbench

Line-oriented main memory controller placed directly downstream of vi_core on its memory bus. It serves 128-bit line reads with a configurable fixed latency. It absorbs the core's 32-bit word and byte stores in a small write buffer, and drains that buffer into the backing array. Writes are always ordered before any later read.

---
 rtl/vi_main_mem.sv | 157 +++++++++++++++
 tb/tb_vi_main_mem.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vi_main_mem.sv
// Line-oriented main memory behind vi_core: fixed-latency 128-bit line reads, write buffer drained ahead of reads.
// Optional access counters when VI_MEM_STATS_EN is defined.
module vi_main_mem #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned LINE_IDX_W = 12,
  parameter int unsigned WB_DEPTH   = 4
) (
  input  logic          clk_i,
  input  logic          rsn_i,
  input  logic          mem_read_i,
  input  logic [19:0]   mem_read_addr_i,
  input  logic          mem_write_enable_i,
  input  logic          mem_write_byte_i,
  input  logic [19:0]   mem_write_addr_i,
  input  logic [31:0]   mem_write_data_i,
  output logic          mem_data_ready_o,
  output logic [127:0]  mem_data_o,
  output logic [19:0]   mem_addr_o,
  output logic          mem_wb_full_o
`ifdef VI_MEM_STATS_EN
  ,
  output logic [31:0]   mem_rd_count_o,
  output logic [31:0]   mem_wr_count_o
`endif
);

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned LINES  = 2 ** LINE_IDX_W;
  localparam int unsigned PTR_W  = $clog2(WB_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, DRAIN, WAIT, RESP, GAP} state_t;

  typedef struct packed {
    logic              is_byte;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  wb_entry_t         wb_q [WB_DEPTH];
  logic [LINE_W-1:0] mem_q [LINES];

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  state_t            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              resp_d;
  logic              push, pop;

  assign mem_wb_full_o = (count_q == CNT_W'(WB_DEPTH));
  assign push = mem_write_enable_i && !mem_wb_full_o;
  // IDLE drains only on cycles without a new store, so a burst of stores can fill the buffer
  assign pop = !rsn_i && (count_q != '0) &&
               (((state_q == IDLE) && !push) || (state_q == DRAIN));
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    rd_addr_d = rd_addr_q;
    resp_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read_i) begin
          rd_addr_d = mem_read_addr_i;
          if (count_d != '0) begin
            state_d = DRAIN;
          end else begin
            state_d = WAIT;
            lat_d   = LAT_W'(LATENCY - 1);
          end
        end
      end
      DRAIN: begin
        if (count_d == '0) begin
          state_d = WAIT;
          lat_d   = LAT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d = RESP;
          resp_d  = 1'b1;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      state_q          <= IDLE;
      lat_q            <= '0;
      rd_addr_q        <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      mem_data_ready_o <= 1'b0;
      mem_data_o       <= '0;
      mem_addr_o       <= '0;
    end else begin
      state_q          <= state_d;
      lat_q            <= lat_d;
      rd_addr_q        <= rd_addr_d;
      count_q          <= count_d;
      mem_data_ready_o <= resp_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (resp_d) begin
        mem_data_o <= mem_q[rd_addr_q[4 +: LINE_IDX_W]];
        mem_addr_o <= rd_addr_q;
      end
    end
  end

  // Buffer payload needs no reset: occupancy is tracked by count_q
  always_ff @(posedge clk_i) begin
    if (push) begin
      wb_q[wr_ptr_q] <= '{is_byte: mem_write_byte_i,
                          addr:    mem_write_addr_i,
                          data:    mem_write_data_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (pop) begin
      if (wb_q[rd_ptr_q].is_byte) begin
        mem_q[wb_q[rd_ptr_q].addr[4 +: LINE_IDX_W]][{wb_q[rd_ptr_q].addr[3:0], 3'b000} +: 8]
          <= wb_q[rd_ptr_q].data[7:0];
      end else begin
        mem_q[wb_q[rd_ptr_q].addr[4 +: LINE_IDX_W]][{wb_q[rd_ptr_q].addr[3:2], 5'b00000} +: 32]
          <= wb_q[rd_ptr_q].data;
      end
    end
  end

`ifdef VI_MEM_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      mem_rd_count_o <= '0;
      mem_wr_count_o <= '0;
    end else begin
      if (state_q == RESP) mem_rd_count_o <= mem_rd_count_o + 32'd1;
      if (push)            mem_wr_count_o <= mem_wr_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vi_main_mem.sv
// Directed self-checking bench for vi_main_mem at default parameters.
module tb_vi_main_mem;

  localparam int LAT = 4;

  logic         clk_i = 1'b0;
  logic         rsn_i = 1'b1;
  logic         mem_read_i = 1'b0;
  logic [19:0]  mem_read_addr_i = '0;
  logic         mem_write_enable_i = 1'b0;
  logic         mem_write_byte_i = 1'b0;
  logic [19:0]  mem_write_addr_i = '0;
  logic [31:0]  mem_write_data_i = '0;
  logic         mem_data_ready_o;
  logic [127:0] mem_data_o;
  logic [19:0]  mem_addr_o;
  logic         mem_wb_full_o;
`ifdef VI_MEM_STATS_EN
  logic [31:0]  mem_rd_count_o, mem_wr_count_o;
`endif

  int checks = 0;
  int passed = 0;

  vi_main_mem dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .mem_read_i(mem_read_i), .mem_read_addr_i(mem_read_addr_i),
    .mem_write_enable_i(mem_write_enable_i), .mem_write_byte_i(mem_write_byte_i),
    .mem_write_addr_i(mem_write_addr_i), .mem_write_data_i(mem_write_data_i),
    .mem_data_ready_o(mem_data_ready_o), .mem_data_o(mem_data_o),
    .mem_addr_o(mem_addr_o), .mem_wb_full_o(mem_wb_full_o)
`ifdef VI_MEM_STATS_EN
    , .mem_rd_count_o(mem_rd_count_o), .mem_wr_count_o(mem_wr_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic store(input logic b, input logic [19:0] a, input logic [31:0] d);
    mem_write_byte_i   = b;
    mem_write_addr_i   = a;
    mem_write_data_i   = d;
    mem_write_enable_i = 1'b1;
    for (int i = 0; i < 20 && mem_wb_full_o; i++) tick();
    tick();
    mem_write_enable_i = 1'b0;
  endtask

  task automatic wait_drain();
    repeat (6) tick();
  endtask

  // Issue a read from IDLE; returns cycles to ready (-1 on timeout), data, echo and the strobe one cycle later
  task automatic do_read(input logic [19:0] a, output logic [127:0] d, output logic [19:0] ea,
                         output int lat, output logic after);
    mem_read_addr_i = a;
    mem_read_i      = 1'b1;
    lat = -1;
    d   = '0;
    ea  = '0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      mem_read_i = 1'b0;
      if (mem_data_ready_o) begin
        lat = i;
        d   = mem_data_o;
        ea  = mem_addr_o;
        break;
      end
    end
    tick();
    after = mem_data_ready_o;
    tick();
  endtask

  task automatic test_reset();
    rsn_i = 1'b1;
    tick(); tick();
    checks++; if (mem_data_ready_o !== 1'b0) $display("FAIL reset_ready got=%0b exp=0", mem_data_ready_o); else passed++;
    checks++; if (mem_data_o !== 128'h0) $display("FAIL reset_data got=%h exp=0", mem_data_o); else passed++;
    checks++; if (mem_addr_o !== 20'h0) $display("FAIL reset_addr got=%h exp=0", mem_addr_o); else passed++;
    checks++; if (mem_wb_full_o !== 1'b0) $display("FAIL reset_full got=%0b exp=0", mem_wb_full_o); else passed++;
    rsn_i = 1'b0;
    tick();
  endtask

  task automatic test_preload_read();
    logic [127:0] d; logic [19:0] ea; int lat; logic after;
    store(1'b0, 20'h01000, 32'h001000B3);
    store(1'b0, 20'h01004, 32'h00108113);
    store(1'b0, 20'h01008, 32'h00F00193);
    store(1'b0, 20'h0100C, 32'h00311133);
    wait_drain();
    do_read(20'h01000, d, ea, lat, after);
    checks++; if (lat !== LAT + 1) $display("FAIL preload_latency got=%0d exp=%0d", lat, LAT + 1); else passed++;
    checks++; if (d !== 128'h00311133_00F00193_00108113_001000B3) $display("FAIL preload_data got=%h exp=00311133_00f00193_00108113_001000b3", d); else passed++;
    checks++; if (ea !== 20'h01000) $display("FAIL preload_addr got=%h exp=01000", ea); else passed++;
    checks++; if (after !== 1'b0) $display("FAIL preload_pulse_width got=%0b exp=0", after); else passed++;
  endtask

  task automatic test_word_store_drain();
    int lat;
    logic [127:0] d;
    store(1'b0, 20'h08000, 32'h11111111);
    store(1'b0, 20'h08004, 32'h22222222);
    store(1'b0, 20'h08008, 32'h33333333);
    store(1'b0, 20'h0800C, 32'h44444444);
    wait_drain();
    // Store and read together: read must wait one DRAIN cycle
    mem_write_byte_i = 1'b0; mem_write_addr_i = 20'h08004; mem_write_data_i = 32'hDEADBEEF;
    mem_write_enable_i = 1'b1;
    mem_read_addr_i = 20'h08000; mem_read_i = 1'b1;
    tick();
    mem_write_enable_i = 1'b0; mem_read_i = 1'b0;
    lat = -1; d = '0;
    for (int i = 2; i <= 40; i++) begin
      tick();
      if (mem_data_ready_o) begin lat = i; d = mem_data_o; break; end
    end
    tick(); tick();
    checks++; if (lat !== LAT + 2) $display("FAIL drain_latency got=%0d exp=%0d", lat, LAT + 2); else passed++;
    checks++; if (d !== 128'h44444444_33333333_DEADBEEF_11111111) $display("FAIL word_store_data got=%h exp=44444444_33333333_deadbeef_11111111", d); else passed++;
  endtask

  task automatic test_byte_store();
    logic [127:0] d; logic [19:0] ea; int lat; logic after;
    store(1'b1, 20'h0800F, 32'h123456AB);
    store(1'b1, 20'h08000, 32'h987654CD);
    wait_drain();
    do_read(20'h08000, d, ea, lat, after);
    checks++; if (d !== 128'hAB444444_33333333_DEADBEEF_111111CD) $display("FAIL byte_store_data got=%h exp=ab444444_33333333_deadbeef_111111cd", d); else passed++;
  endtask

  task automatic test_wb_full();
    logic [127:0] d; logic [19:0] ea; int lat; logic after;
    mem_write_byte_i = 1'b0; mem_write_enable_i = 1'b1;
    mem_write_addr_i = 20'h02000; mem_write_data_i = 32'hA0A0A0A0; tick();
    mem_write_addr_i = 20'h02004; mem_write_data_i = 32'hA1A1A1A1; tick();
    mem_write_addr_i = 20'h02008; mem_write_data_i = 32'hA2A2A2A2; tick();
    checks++; if (mem_wb_full_o !== 1'b0) $display("FAIL full_after_3 got=%0b exp=0", mem_wb_full_o); else passed++;
    mem_write_addr_i = 20'h0200C; mem_write_data_i = 32'hA3A3A3A3; tick();
    checks++; if (mem_wb_full_o !== 1'b1) $display("FAIL full_after_4 got=%0b exp=1", mem_wb_full_o); else passed++;
    mem_write_addr_i = 20'h02010; mem_write_data_i = 32'hA4A4A4A4; tick();
    checks++; if (mem_wb_full_o !== 1'b0) $display("FAIL full_drop got=%0b exp=0", mem_wb_full_o); else passed++;
    tick();
    checks++; if (mem_wb_full_o !== 1'b1) $display("FAIL full_after_5th got=%0b exp=1", mem_wb_full_o); else passed++;
    mem_write_enable_i = 1'b0;
    wait_drain();
    do_read(20'h02000, d, ea, lat, after);
    checks++; if (d !== 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0) $display("FAIL full_line0 got=%h exp=a3a3a3a3_a2a2a2a2_a1a1a1a1_a0a0a0a0", d); else passed++;
    do_read(20'h02010, d, ea, lat, after);
    checks++; if (d[31:0] !== 32'hA4A4A4A4) $display("FAIL full_fifth got=%h exp=a4a4a4a4", d[31:0]); else passed++;
  endtask

  task automatic test_hold_read();
    int first, second, pulses;
    first = -1; second = -1; pulses = 0;
    mem_read_addr_i = 20'h01000;
    mem_read_i = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (mem_data_ready_o) begin
        pulses++;
        if (first < 0) first = i; else if (second < 0) second = i;
      end
    end
    mem_read_i = 1'b0;
    tick();
    checks++; if (first !== LAT + 1) $display("FAIL hold_first got=%0d exp=%0d", first, LAT + 1); else passed++;
    checks++; if (second !== 2 * LAT + 4) $display("FAIL hold_second got=%0d exp=%0d", second, 2 * LAT + 4); else passed++;
    checks++; if (pulses !== 2) $display("FAIL hold_pulses got=%0d exp=2", pulses); else passed++;
  endtask

  task automatic test_reset_in_wait();
    logic [127:0] d; logic [19:0] ea; int lat; logic after; int pulses;
    mem_read_addr_i = 20'h08000; mem_read_i = 1'b1;
    tick();
    mem_read_i = 1'b0;
    mem_write_byte_i = 1'b0; mem_write_enable_i = 1'b1;
    mem_write_addr_i = 20'h08000; mem_write_data_i = 32'h55555555; tick();
    mem_write_addr_i = 20'h08004; mem_write_data_i = 32'h66666666; tick();
    mem_write_enable_i = 1'b0;
    rsn_i = 1'b1;
    tick();
    checks++; if (mem_data_ready_o !== 1'b0) $display("FAIL rstwait_ready got=%0b exp=0", mem_data_ready_o); else passed++;
    checks++; if (mem_data_o !== 128'h0) $display("FAIL rstwait_data got=%h exp=0", mem_data_o); else passed++;
    checks++; if (mem_addr_o !== 20'h0) $display("FAIL rstwait_addr got=%h exp=0", mem_addr_o); else passed++;
    checks++; if (mem_wb_full_o !== 1'b0) $display("FAIL rstwait_full got=%0b exp=0", mem_wb_full_o); else passed++;
    rsn_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_data_ready_o) pulses++;
    end
    checks++; if (pulses !== 0) $display("FAIL rstwait_no_resp got=%0d exp=0", pulses); else passed++;
    do_read(20'h08000, d, ea, lat, after);
    checks++; if (lat !== LAT + 1) $display("FAIL rstwait_empty_latency got=%0d exp=%0d", lat, LAT + 1); else passed++;
    checks++; if (d !== 128'hAB444444_33333333_DEADBEEF_111111CD) $display("FAIL rstwait_prestore got=%h exp=ab444444_33333333_deadbeef_111111cd", d); else passed++;
  endtask

  task automatic test_alias();
    logic [127:0] d; logic [19:0] ea; int lat; logic after;
    store(1'b0, 20'h1800E, 32'h77777777);
    wait_drain();
    do_read(20'h08000, d, ea, lat, after);
    checks++; if (d !== 128'h77777777_33333333_DEADBEEF_111111CD) $display("FAIL alias_data got=%h exp=77777777_33333333_deadbeef_111111cd", d); else passed++;
    checks++; if (ea !== 20'h08000) $display("FAIL alias_addr got=%h exp=08000", ea); else passed++;
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_word_store_drain();
    test_byte_store();
    test_wb_full();
    test_hold_read();
    test_reset_in_wait();
    test_alias();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
